serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Parametrised digit-serial N-bit subtractor.
- Computes diff = a - b - bin, processing DIGIT bits per clock, LSB digit first, with a ripple borrow carried between cycles.
- Successor to the single-bit full subtractor cell. Trades latency for area in wide datapaths.
- Driven by a start/busy/done handshake from a controlling block.

Parameters:
- WIDTH, 8, operand and result width in bits (>=1).
- DIGIT, 1, bits processed per cycle. Must divide WIDTH exactly; a mismatch is an elaboration-time error.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request. Sampled only in IDLE.
- a  input  WIDTH  minuend. Captured on an accepted start.
- b  input  WIDTH  subtrahend. Captured on an accepted start.
- bin  input  1  borrow-in. Captured on an accepted start.
- busy  output  1  high while digits are being processed.
- done  output  1  one-cycle pulse; result valid.
- diff  output  WIDTH  result, registered.
- bout  output  1  final borrow-out, registered.

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, diff=0, bout=0; internal operand/borrow/digit-counter registers cleared.
- N = WIDTH/DIGIT digits.
- FSM states and transitions:
  - IDLE: start=1 at an edge -> latch a, b, and bin (bin loaded as running borrow); counter=0 -> RUN.
  - RUN: each edge processes the digit at index counter.
    - {brw_next, d} = a_dig - b_dig - brw, computed at DIGIT+1 bits.
    - d is written into result slice [counter*DIGIT +: DIGIT].
    - counter increments.
    - On the edge processing digit N-1 -> DONE; the final borrow is loaded into bout.
  - DONE: lasts exactly one cycle, then -> IDLE.
- Outputs by state:
  - busy=1 exactly in RUN.
  - done=1 exactly in DONE.
- Timing: start sampled at edge 0 -> digits processed at edges 1..N -> done high between edges N and N+1. Start-to-done latency is N+1 edges.
- diff/bout update only on the transition into DONE. They hold their value through IDLE and through the next operation until that operation completes.
- Operands are captured at start. a, b and bin may change freely afterwards without affecting the result.
- start while in RUN or DONE: ignored; no queueing.
- start held continuously high: a new operation begins the edge after DONE. Back-to-back throughput is one result per N+2 cycles.
- Arithmetic is modulo 2^WIDTH.
  - bout=1 iff a < b + bin as unsigned values.
  - Result equals the single-cycle expression {bout, diff} = {1'b0,a} - {1'b0,b} - bin.
- WIDTH=1, DIGIT=1: behaves as a registered full subtractor, i.e. diff = a^b^bin and bout = (~a&b) | (~a&bin) | (b&bin).
- Reset mid-operation: immediate abort to IDLE with all outputs zeroed; no done pulse.

Optional Feature:
- Macro: SERIAL_SUBTRACTOR_OVF_EN.
- When defined:
  - Adds output port ovf (1 bit) for signed two's-complement overflow.
  - ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), evaluated on the captured operands.
  - Registered alongside diff: reset 0, updated only on entry to DONE.
- When undefined: the ovf port and its logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=8, DIGIT=1; a=0x05, b=0x03, bin=0 -> busy high for 8 cycles, done pulses on cycle 9 after start, diff=0x02, bout=0.
- WIDTH=8, DIGIT=1 borrow cases:
  - a=0x03, b=0x05, bin=0 -> diff=0xFE, bout=1.
  - a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1.
  - After each case, a/b change while busy -> result unaffected.
- WIDTH=1, DIGIT=1: all 8 {a,b,bin} combinations 000..111 -> diff and bout match the full-subtractor truth table. Example: 011 -> diff=0, bout=1; 100 -> diff=1, bout=0. done follows each start by 2 edges.
- WIDTH=8, DIGIT=4; a=0xA7, b=0x3C, bin=0 -> done 3 edges after start, diff=0x6B, bout=0. A second start pulsed mid-RUN is ignored (exactly one done pulse).
- Reset and start-hold:
  - rst asserted during digit 4 of an 8-digit operation -> busy, done, diff and bout are 0 immediately (asynchronously).
  - A new start after reset runs correctly.
  - start held high -> consecutive done pulses N+2 cycles apart.
- With SERIAL_SUBTRACTOR_OVF_EN, WIDTH=8:
  - a=0x80, b=0x01 -> diff=0x7F, ovf=1.
  - a=0x7F, b=0xFF -> diff=0x80, ovf=1, bout=1.
  - a=0x05, b=0x03 -> ovf=0.

Source files
------------

// File: rtl/serial_subtractor.sv
// serial_subtractor: digit-serial WIDTH-bit subtractor, diff = a - b - bin, DIGIT bits per clock, LSB digit first
//
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-high reset
//   start - request, sampled only in IDLE
//   a, b  - minuend / subtrahend, captured on an accepted start
//   bin   - borrow-in, captured on an accepted start
//   busy  - high while digits are being processed (RUN)
//   done  - one-cycle pulse, diff/bout valid
//   diff  - registered result
//   bout  - registered final borrow-out
//   ovf   - registered signed overflow (only with SERIAL_SUBTRACTOR_OVF_EN defined)
//
// Optional feature macro: SERIAL_SUBTRACTOR_OVF_EN adds the ovf output.
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    output logic             ovf,
`endif
    output logic             bout
);

    generate
        if ((WIDTH < 1) || (DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_bad_param
            $error("serial_subtractor: DIGIT must be >= 1 and divide WIDTH exactly");
        end
    endgenerate

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              brw_q, brw_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic [WIDTH-1:0]  diff_q, diff_d;
    logic              bout_q, bout_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic              ovf_q, ovf_d;
`endif

    logic              last_dig;
    logic [DIGIT-1:0]  a_dig;
    logic [DIGIT-1:0]  b_dig;
    logic [DIGIT:0]    dig_sub;
    logic [WIDTH-1:0]  res_upd;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            brw_q   <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            brw_q   <= brw_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? RUN : IDLE;
            RUN:     state_d = last_dig ? DONE : RUN;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // One digit of the ripple: the top bit of the (DIGIT+1)-bit difference is the borrow out
    always_comb begin
        last_dig = (cnt_q == CW'(N - 1));
        a_dig    = a_q[int'(cnt_q) * DIGIT +: DIGIT];
        b_dig    = b_q[int'(cnt_q) * DIGIT +: DIGIT];
        dig_sub  = {1'b0, a_dig} - {1'b0, b_dig} - (DIGIT + 1)'(brw_q);
        res_upd  = res_q;
        res_upd[int'(cnt_q) * DIGIT +: DIGIT] = dig_sub[DIGIT-1:0];
    end

    // Datapath next values; diff/bout/ovf only move on the edge that enters DONE
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        brw_d  = brw_q;
        cnt_d  = cnt_q;
        res_d  = res_q;
        diff_d = diff_q;
        bout_d = bout_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        ovf_d  = ovf_q;
`endif
        if (state_q == IDLE && start) begin
            a_d   = a;
            b_d   = b;
            brw_d = bin;
            cnt_d = '0;
            res_d = '0;
        end
        if (state_q == RUN) begin
            brw_d = dig_sub[DIGIT];
            cnt_d = cnt_q + CW'(1);
            res_d = res_upd;
            if (last_dig) begin
                diff_d = res_upd;
                bout_d = dig_sub[DIGIT];
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                ovf_d  = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (res_upd[WIDTH-1] != a_q[WIDTH-1]);
`endif
            end
        end
    end

    // Outputs
    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
        diff = diff_q;
        bout = bout_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        ovf  = ovf_q;
`endif
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed self-checking bench for serial_subtractor (8/1, 1/1 and 8/4 configurations)
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       s8 = 0, bi8 = 0, busy8, done8, bout8;
    logic [7:0] a8 = 0, b8 = 0, diff8;
    logic       s1 = 0, bi1 = 0, busy1, done1, bout1;
    logic [0:0] a1 = 0, b1 = 0, diff1;
    logic       s4 = 0, bi4 = 0, busy4, done4, bout4;
    logic [7:0] a4 = 0, b4 = 0, diff4;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic ovf8, ovf1, ovf4;
`endif

    int tests = 0;
    int fails = 0;

    serial_subtractor #(.WIDTH(8), .DIGIT(1)) u8 (
        .clk(clk), .rst(rst), .start(s8), .a(a8), .b(b8), .bin(bi8),
        .busy(busy8), .done(done8), .diff(diff8),
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        .ovf(ovf8),
`endif
        .bout(bout8));

    serial_subtractor #(.WIDTH(1), .DIGIT(1)) u1 (
        .clk(clk), .rst(rst), .start(s1), .a(a1), .b(b1), .bin(bi1),
        .busy(busy1), .done(done1), .diff(diff1),
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        .ovf(ovf1),
`endif
        .bout(bout1));

    serial_subtractor #(.WIDTH(8), .DIGIT(4)) u4 (
        .clk(clk), .rst(rst), .start(s4), .a(a4), .b(b4), .bin(bi4),
        .busy(busy4), .done(done4), .diff(diff4),
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        .ovf(ovf4),
`endif
        .bout(bout4));

    function automatic logic get_busy(input int sel);
        return (sel == 1) ? busy1 : (sel == 4) ? busy4 : busy8;
    endfunction

    function automatic logic get_done(input int sel);
        return (sel == 1) ? done1 : (sel == 4) ? done4 : done8;
    endfunction

    task automatic set_in(input int sel, input logic s, input logic [7:0] a, input logic [7:0] b, input logic bi);
        if (sel == 1) begin s1 = s; a1 = a[0]; b1 = b[0]; bi1 = bi; end
        else if (sel == 4) begin s4 = s; a4 = a; b4 = b; bi4 = bi; end
        else begin s8 = s; a8 = a; b8 = b; bi8 = bi; end
    endtask

    // Drives one operation and measures negedges until done (lat) and busy cycles seen (bcnt).
    // lat is 99 if done never arrived within the bound.
    task automatic run_op(input int sel, input logic [7:0] a, input logic [7:0] b, input logic bi,
                          input bit scramble, output int lat, output int bcnt);
        bit seen;
        @(negedge clk);
        set_in(sel, 1'b1, a, b, bi);
        lat = 0;
        bcnt = 0;
        seen = 0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            set_in(sel, 1'b0, scramble ? ~a : a, scramble ? ~b : b, scramble ? ~bi : bi);
            if (get_busy(sel)) bcnt++;
            if (get_done(sel)) seen = 1;
        end
        if (!seen) lat = 99;
    endtask

    task automatic test_reset;
        tests++; if (busy8 !== 1'b0) begin fails++; $display("FAIL reset busy8 got %b want 0", busy8); end
        tests++; if (done8 !== 1'b0) begin fails++; $display("FAIL reset done8 got %b want 0", done8); end
        tests++; if (diff8 !== 8'h00) begin fails++; $display("FAIL reset diff8 got %h want 00", diff8); end
        tests++; if (bout8 !== 1'b0) begin fails++; $display("FAIL reset bout8 got %b want 0", bout8); end
        tests++; if ({busy1, done1, diff1, bout1} !== 4'b0) begin fails++; $display("FAIL reset u1 got %b want 0000", {busy1, done1, diff1, bout1}); end
        tests++; if ({busy4, done4, diff4, bout4} !== 11'b0) begin fails++; $display("FAIL reset u4 got %h want 000", {busy4, done4, diff4, bout4}); end
    endtask

    task automatic test_basic;
        int lat, bcnt;
        run_op(8, 8'h05, 8'h03, 1'b0, 0, lat, bcnt);
        tests++; if (lat !== 9) begin fails++; $display("FAIL basic latency got %0d want 9", lat); end
        tests++; if (bcnt !== 8) begin fails++; $display("FAIL basic busy cycles got %0d want 8", bcnt); end
        tests++; if (diff8 !== 8'h02) begin fails++; $display("FAIL basic diff got %h want 02", diff8); end
        tests++; if (bout8 !== 1'b0) begin fails++; $display("FAIL basic bout got %b want 0", bout8); end
        @(negedge clk);
        tests++; if (done8 !== 1'b0) begin fails++; $display("FAIL basic done width got %b want 0", done8); end
        tests++; if (diff8 !== 8'h02) begin fails++; $display("FAIL basic diff hold got %h want 02", diff8); end
    endtask

    task automatic test_borrow;
        int lat, bcnt;
        run_op(8, 8'h03, 8'h05, 1'b0, 1, lat, bcnt);
        tests++; if ({diff8, bout8} !== {8'hFE, 1'b1}) begin fails++; $display("FAIL borrow 03-05 got %h/%b want fe/1", diff8, bout8); end
        run_op(8, 8'h00, 8'h00, 1'b1, 1, lat, bcnt);
        tests++; if ({diff8, bout8} !== {8'hFF, 1'b1}) begin fails++; $display("FAIL borrow 00-00-1 got %h/%b want ff/1", diff8, bout8); end
        run_op(8, 8'hFF, 8'hFE, 1'b1, 1, lat, bcnt);
        tests++; if ({diff8, bout8} !== {8'h00, 1'b0}) begin fails++; $display("FAIL borrow ff-fe-1 got %h/%b want 00/0", diff8, bout8); end
    endtask

    task automatic test_width1;
        int lat, bcnt;
        logic ea, eb, ec, ed, eo;
        for (int i = 0; i < 8; i++) begin
            ea = i[2]; eb = i[1]; ec = i[0];
            ed = ea ^ eb ^ ec;
            eo = (~ea & eb) | (~ea & ec) | (eb & ec);
            run_op(1, {7'b0, ea}, {7'b0, eb}, ec, 1, lat, bcnt);
            tests++; if (lat !== 2) begin fails++; $display("FAIL w1 latency %0d got %0d want 2", i, lat); end
            tests++; if ({diff1, bout1} !== {ed, eo}) begin fails++; $display("FAIL w1 abc=%0d got %b%b want %b%b", i, diff1, bout1, ed, eo); end
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            tests++; if (ovf1 !== ((ea != eb) && (ed != ea))) begin fails++; $display("FAIL w1 ovf abc=%0d got %b", i, ovf1); end
`endif
        end
    endtask

    task automatic test_digit4;
        int lat, bcnt, dones;
        run_op(4, 8'hA7, 8'h3C, 1'b0, 0, lat, bcnt);
        tests++; if (lat !== 3) begin fails++; $display("FAIL d4 latency got %0d want 3", lat); end
        tests++; if ({diff4, bout4} !== {8'h6B, 1'b0}) begin fails++; $display("FAIL d4 a7-3c got %h/%b want 6b/0", diff4, bout4); end
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        tests++; if (ovf4 !== 1'b1) begin fails++; $display("FAIL d4 ovf got %b want 1", ovf4); end
`endif
        // second start pulsed while the first op is in RUN must be ignored
        @(negedge clk);
        set_in(4, 1'b1, 8'h10, 8'h01, 1'b0);
        dones = 0;
        @(negedge clk);
        if (done4) dones++;
        set_in(4, 1'b1, 8'h22, 8'h11, 1'b0);
        @(negedge clk);
        if (done4) dones++;
        set_in(4, 1'b0, 8'h22, 8'h11, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done4) dones++;
        end
        tests++; if (dones !== 1) begin fails++; $display("FAIL d4 ignored start done pulses got %0d want 1", dones); end
        tests++; if (diff4 !== 8'h0F) begin fails++; $display("FAIL d4 ignored start diff got %h want 0f", diff4); end
    endtask

    task automatic test_reset_mid;
        int lat, bcnt, dones;
        run_op(8, 8'h05, 8'h03, 1'b0, 0, lat, bcnt);
        @(negedge clk);
        set_in(8, 1'b1, 8'hFF, 8'h01, 1'b0);
        @(negedge clk);
        set_in(8, 1'b0, 8'hFF, 8'h01, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        tests++; if ({busy8, done8, diff8, bout8} !== 11'b0) begin fails++; $display("FAIL midreset async got %b%b %h %b want all 0", busy8, done8, diff8, bout8); end
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8 || busy8) dones++;
        end
        tests++; if (dones !== 0) begin fails++; $display("FAIL midreset activity after abort got %0d want 0", dones); end
        run_op(8, 8'h10, 8'h01, 1'b0, 0, lat, bcnt);
        tests++; if (lat !== 9 || {diff8, bout8} !== {8'h0F, 1'b0}) begin fails++; $display("FAIL midreset rerun got lat %0d %h/%b want 9 0f/0", lat, diff8, bout8); end
    endtask

    task automatic test_back_to_back;
        int t[3];
        int n, cyc;
        logic prev;
        @(negedge clk);
        set_in(4, 1'b1, 8'h10, 8'h20, 1'b0);
        n = 0; cyc = 0; prev = 0;
        while (n < 3 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (done4 && !prev) begin t[n] = cyc; n++; end
            prev = done4;
        end
        set_in(4, 1'b0, 8'h10, 8'h20, 1'b0);
        tests++; if (n !== 3) begin fails++; $display("FAIL b2b done count got %0d want 3", n); end
        else begin
            tests++; if (t[1] - t[0] !== 4) begin fails++; $display("FAIL b2b spacing1 got %0d want 4", t[1] - t[0]); end
            tests++; if (t[2] - t[1] !== 4) begin fails++; $display("FAIL b2b spacing2 got %0d want 4", t[2] - t[1]); end
        end
        tests++; if ({diff4, bout4} !== {8'hF0, 1'b1}) begin fails++; $display("FAIL b2b result got %h/%b want f0/1", diff4, bout4); end
        repeat (6) @(negedge clk);
    endtask

`ifdef SERIAL_SUBTRACTOR_OVF_EN
    task automatic test_ovf;
        int lat, bcnt;
        run_op(8, 8'h80, 8'h01, 1'b0, 1, lat, bcnt);
        tests++; if ({diff8, ovf8, bout8} !== {8'h7F, 1'b1, 1'b0}) begin fails++; $display("FAIL ovf 80-01 got %h/%b/%b want 7f/1/0", diff8, ovf8, bout8); end
        run_op(8, 8'h7F, 8'hFF, 1'b0, 1, lat, bcnt);
        tests++; if ({diff8, ovf8, bout8} !== {8'h80, 1'b1, 1'b1}) begin fails++; $display("FAIL ovf 7f-ff got %h/%b/%b want 80/1/1", diff8, ovf8, bout8); end
        run_op(8, 8'h05, 8'h03, 1'b0, 1, lat, bcnt);
        tests++; if ({diff8, ovf8} !== {8'h02, 1'b0}) begin fails++; $display("FAIL ovf 05-03 got %h/%b want 02/0", diff8, ovf8); end
    endtask
`endif

    initial begin
        repeat (3) @(negedge clk);
        test_reset;
        rst = 1'b0;
        test_basic;
        test_borrow;
        test_width1;
        test_digit4;
        test_reset_mid;
        test_back_to_back;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        test_ovf;
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
